voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter VOICES, default 32: number of synth voices to schedule.
REQ-002 Parameter V_WIDTH, default utils::clogb2(VOICES) = 5: voice index width.
REQ-003 AUDIO_CLK  in  1  sole clock; one clock, all state on rising edge.
REQ-004 reset_reg_N  in  1  asynchronous, active-low reset.
REQ-005 ev_valid  in  1  note event request; ev_ready  out  1  high only in IDLE; transfer when both high.
REQ-006 ev_note_on  in  1  1=note-on, 0=note-off; ev_key  in  8  MIDI key; ev_vel  in  8  velocity.
REQ-007 voice_free  in  VOICES  per-voice envelope-idle flags from envelope generator.
REQ-008 keys_on  out  VOICES  per-voice gate to synth engine.
REQ-009 note_on  out  1  one-cycle pulse, voice assigned; note_off  out  1  one-cycle pulse, voice released.
REQ-010 cur_key_adr  out  V_WIDTH, cur_key_val  out  8, cur_vel_on  out  8, cur_vel_off  out  8: registered event result.
REQ-011 steal  out  1  one-cycle pulse with note_on when a busy voice is reassigned; ev_dropped  out  1  one-cycle pulse when a note-on or unmatched note-off is discarded.

Function
REQ-012 FSM states IDLE, SCAN, COMMIT; IDLE->SCAN on transfer; SCAN->COMMIT after index VOICES-1 evaluated; COMMIT->IDLE unconditionally.
REQ-013 Transfer latches ev_note_on/ev_key/ev_vel; ev_valid ignored outside IDLE.
REQ-014 SCAN evaluates one voice index per cycle, 0 to VOICES-1, sampling voice_free[i] and keys_on[i] in that cycle.
REQ-015 Note-on candidate priority: (1) keys_on[i]=1 and stored key==ev_key (retrigger); (2) voice_free[i]=1 and keys_on[i]=0; (3) keys_on[i]=0, voice_free[i]=0, oldest; (4) keys_on[i]=1, oldest.
REQ-016 Ties within tier (1)/(2): lowest index wins; tiers (3)/(4): largest age wins, then lowest index.
REQ-017 Age = (seq - stamp[i]) mod 2^16; seq is a 16-bit counter incremented on every note_on pulse, wrapping freely.
REQ-018 Note-on COMMIT: keys_on[v]<=1, stamp[v]<=seq, key[v]<=ev_key, cur_key_adr<=v, cur_key_val<=ev_key, cur_vel_on<=ev_vel, note_on=1; steal=1 when v came from tier (3) or (4).
REQ-019 Note-off: match keys_on[i]=1 and key[i]==ev_key, lowest index; COMMIT: keys_on[v]<=0, cur_key_adr<=v, cur_vel_off<=ev_vel, note_off=1.
REQ-020 Unmatched note-off: no state change except ev_dropped=1 in COMMIT.
REQ-021 Latency: transfer edge to note_on/note_off pulse = VOICES+1 cycles; next transfer possible VOICES+2 cycles after previous.
REQ-022 cur_* outputs hold between commits; keys_on changes only in COMMIT.

Reset
REQ-023 On reset_reg_N low, immediately: state IDLE, keys_on=0, key[]=0, stamp[]=0, seq=0, cur_key_adr=0, cur_key_val=0, cur_vel_on=0, cur_vel_off=0, note_on=0, note_off=0, steal=0, ev_dropped=0.
REQ-024 ev_ready=1 during and after reset.
REQ-025 Reset asserted mid-SCAN aborts the event; no pulse is issued for it after release.

Configuration
REQ-026 Macro VOICE_STEAL_EN defined: tiers (3) and (4) enabled; note-on never dropped.
REQ-027 Macro VOICE_STEAL_EN undefined: only tiers (1)/(2); note-on with no candidate yields ev_dropped=1, no note_on, no state change; steal tied 0.

Verification
REQ-028 After reset, all voice_free=1, note-on key 60 vel 100 -> after 33 cycles note_on=1, cur_key_adr=0, cur_key_val=60, cur_vel_on=100, keys_on=0x00000001.
REQ-029 Note-on key 60 then 64 then note-off key 60 vel 40 -> keys_on 0x1, 0x3, then 0x2; note_off with cur_key_adr=0, cur_vel_off=40.
REQ-030 Note-on key 60 twice -> second note_on cur_key_adr=0 (retrigger), keys_on=0x1, steal=0.
REQ-031 VOICE_STEAL_EN, 32 distinct note-ons, voice_free held 0, then key 100 -> note_on cur_key_adr=0, steal=1; without macro -> ev_dropped=1, keys_on unchanged 0xFFFFFFFF.
REQ-032 Note-off key 77 never played -> ev_dropped=1, keys_on unchanged; reset pulse mid-SCAN -> no pulse, keys_on=0, ev_ready=1.

Source files
------------

// File: rtl/voice_allocator.sv
// Voice allocator: scans voices serially to assign or release synth voices.
// Optional voice stealing (tiers 3/4) enabled by defining VOICE_STEAL_EN.
module voice_allocator #(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = $clog2(VOICES)
) (
  input  logic               AUDIO_CLK,
  input  logic               reset_reg_N,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_note_on,
  input  logic [7:0]         ev_key,
  input  logic [7:0]         ev_vel,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic               note_off,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic               steal,
  output logic               ev_dropped
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t state_q, state_d;

  logic               on_q;
  logic [7:0]         key_q;
  logic [7:0]         vel_q;
  logic [V_WIDTH-1:0] idx_q;
  logic [2:0]         cand_tier;
  logic [V_WIDTH-1:0] cand_idx;
  logic [15:0]        cand_age;
  logic [15:0]        seq;
  logic [7:0]         key_mem   [VOICES];
  logic [15:0]        stamp_mem [VOICES];

  logic        xfer;
  logic        last;
  logic        busy_i;
  logic        free_i;
  logic        hit_i;
  logic [15:0] age_i;
  logic [2:0]  tier_i;
  logic        better;

  assign ev_ready = (state_q == IDLE);
  assign xfer     = ev_valid && ev_ready;
  assign last     = (idx_q == V_WIDTH'(VOICES - 1));

  assign busy_i = keys_on[idx_q];
  assign free_i = voice_free[idx_q];
  assign hit_i  = busy_i && (key_mem[idx_q] == key_q);
  assign age_i  = seq - stamp_mem[idx_q];

  // Tier 1 is best; 0 means not a candidate
  always_comb begin
    tier_i = 3'd0;
    if (hit_i)
      tier_i = 3'd1;
    else if (on_q && free_i && !busy_i)
      tier_i = 3'd2;
`ifdef VOICE_STEAL_EN
    else if (on_q && !busy_i)
      tier_i = 3'd3;
    else if (on_q)
      tier_i = 3'd4;
`endif
  end

  // Ascending scan: equal rank keeps the earlier (lower) index
  always_comb begin
    better = 1'b0;
    if (tier_i != 3'd0) begin
      if (cand_tier == 3'd0 || tier_i < cand_tier)
        better = 1'b1;
      else if (tier_i == cand_tier && tier_i >= 3'd3
               && age_i > cand_age)
        better = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (xfer) state_d = SCAN;
      SCAN:    if (last) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      on_q        <= 1'b0;
      key_q       <= '0;
      vel_q       <= '0;
      idx_q       <= '0;
      cand_tier   <= '0;
      cand_idx    <= '0;
      cand_age    <= '0;
      seq         <= '0;
      keys_on     <= '0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      cur_vel_off <= '0;
      note_on     <= 1'b0;
      note_off    <= 1'b0;
      steal       <= 1'b0;
      ev_dropped  <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        key_mem[i]   <= '0;
        stamp_mem[i] <= '0;
      end
    end else begin
      note_on    <= 1'b0;
      note_off   <= 1'b0;
      steal      <= 1'b0;
      ev_dropped <= 1'b0;
      if (state_q == IDLE) begin
        if (xfer) begin
          on_q      <= ev_note_on;
          key_q     <= ev_key;
          vel_q     <= ev_vel;
          idx_q     <= '0;
          cand_tier <= '0;
          cand_idx  <= '0;
          cand_age  <= '0;
        end
      end else if (state_q == SCAN) begin
        idx_q <= idx_q + 1'b1;
        if (better) begin
          cand_tier <= tier_i;
          cand_idx  <= idx_q;
          cand_age  <= age_i;
        end
      end else if (state_q == COMMIT) begin
        if (cand_tier == 3'd0) begin
          ev_dropped <= 1'b1;
        end else if (on_q) begin
          keys_on[cand_idx]   <= 1'b1;
          stamp_mem[cand_idx] <= seq;
          key_mem[cand_idx]   <= key_q;
          cur_key_adr         <= cand_idx;
          cur_key_val         <= key_q;
          cur_vel_on          <= vel_q;
          note_on             <= 1'b1;
          seq                 <= seq + 16'd1;
`ifdef VOICE_STEAL_EN
          steal               <= (cand_tier >= 3'd3);
`else
          steal               <= 1'b0;
`endif
        end else begin
          keys_on[cand_idx] <= 1'b0;
          cur_key_adr       <= cand_idx;
          cur_vel_off       <= vel_q;
          note_off          <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: event table, fill/steal sequence, mid-scan reset.
// Honours VOICE_STEAL_EN for the full-pool note-on expectation.
module tb_voice_allocator;

  localparam int VOICES = 32;
  localparam logic [2:0] K_ON   = 3'b001;
  localparam logic [2:0] K_OFF  = 3'b010;
  localparam logic [2:0] K_DROP = 3'b100;

  logic        AUDIO_CLK = 1'b0;
  logic        reset_reg_N = 1'b1;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_note_on;
  logic [7:0]  ev_key;
  logic [7:0]  ev_vel;
  logic [31:0] voice_free;
  logic [31:0] keys_on;
  logic        note_on;
  logic        note_off;
  logic [4:0]  cur_key_adr;
  logic [7:0]  cur_key_val;
  logic [7:0]  cur_vel_on;
  logic [7:0]  cur_vel_off;
  logic        steal;
  logic        ev_dropped;

  voice_allocator #(.VOICES(VOICES)) dut (
    .AUDIO_CLK   (AUDIO_CLK),
    .reset_reg_N (reset_reg_N),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_note_on  (ev_note_on),
    .ev_key      (ev_key),
    .ev_vel      (ev_vel),
    .voice_free  (voice_free),
    .keys_on     (keys_on),
    .note_on     (note_on),
    .note_off    (note_off),
    .cur_key_adr (cur_key_adr),
    .cur_key_val (cur_key_val),
    .cur_vel_on  (cur_vel_on),
    .cur_vel_off (cur_vel_off),
    .steal       (steal),
    .ev_dropped  (ev_dropped)
  );

  always #5 AUDIO_CLK = ~AUDIO_CLK;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  adr;
    logic [7:0]  val;
    logic [7:0]  vel;
    logic [31:0] keys;
    logic        stl;
  } exp_t;

  typedef struct {
    logic        on;
    logic [7:0]  key;
    logic [7:0]  vel;
    logic [31:0] free;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t mk(input logic [2:0] kind, input logic [4:0] adr,
                              input logic [7:0] val, input logic [7:0] vel,
                              input logic [31:0] keys, input logic stl);
    exp_t e;
    e.kind = kind;
    e.adr  = adr;
    e.val  = val;
    e.vel  = vel;
    e.keys = keys;
    e.stl  = stl;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic send(input logic on, input logic [7:0] key,
                      input logic [7:0] vel, input exp_t e);
    exp_t x;
    int   n;
    logic seen;
    exp_q.push_back(e);
    ev_note_on = on;
    ev_key     = key;
    ev_vel     = vel;
    ev_valid   = 1'b1;
    n = 0;
    while (!ev_ready && n < 100) begin
      @(posedge AUDIO_CLK); #1;
      n++;
    end
    @(posedge AUDIO_CLK); #1;
    ev_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(posedge AUDIO_CLK); #1;
      n++;
      seen = note_on | note_off | ev_dropped;
    end
    x = exp_q.pop_front();
    check("latency", n, 33);
    check("kind", {29'd0, ev_dropped, note_off, note_on}, {29'd0, x.kind});
    check("keys_on", keys_on, x.keys);
    check("steal", {31'd0, steal}, {31'd0, x.stl});
    if (x.kind == K_ON) begin
      check("on_adr", {27'd0, cur_key_adr}, {27'd0, x.adr});
      check("on_key", {24'd0, cur_key_val}, {24'd0, x.val});
      check("on_vel", {24'd0, cur_vel_on}, {24'd0, x.vel});
    end else if (x.kind == K_OFF) begin
      check("off_adr", {27'd0, cur_key_adr}, {27'd0, x.adr});
      check("off_vel", {24'd0, cur_vel_off}, {24'd0, x.vel});
    end
    @(posedge AUDIO_CLK); #1;
    check("pulse_width", {29'd0, ev_dropped, note_off, note_on}, 32'd0);
  endtask

  task automatic do_reset();
    reset_reg_N = 1'b0;
    #2;
    check("rst_ready", {31'd0, ev_ready}, 32'd1);
    check("rst_keys", keys_on, 32'd0);
    check("rst_cur", {cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off}, 32'd0);
    check("rst_pulses", {28'd0, note_on, note_off, steal, ev_dropped}, 32'd0);
    @(posedge AUDIO_CLK); #1;
    reset_reg_N = 1'b1;
    @(posedge AUDIO_CLK); #1;
    check("post_rst_ready", {31'd0, ev_ready}, 32'd1);
  endtask

  vec_t vt[8];
  logic [31:0] all_on;
  logic [31:0] mask;
  logic        seen;

  initial begin
    ev_valid   = 1'b0;
    ev_note_on = 1'b0;
    ev_key     = '0;
    ev_vel     = '0;
    voice_free = '1;
    all_on     = '1;

    vt[0] = '{1'b1, 8'd60, 8'd100, 32'hFFFFFFFF,
              mk(K_ON, 5'd0, 8'd60, 8'd100, 32'h1, 1'b0)};
    vt[1] = '{1'b1, 8'd64, 8'd90, 32'hFFFFFFFF,
              mk(K_ON, 5'd1, 8'd64, 8'd90, 32'h3, 1'b0)};
    vt[2] = '{1'b0, 8'd60, 8'd40, 32'hFFFFFFFF,
              mk(K_OFF, 5'd0, 8'd0, 8'd40, 32'h2, 1'b0)};
    vt[3] = '{1'b1, 8'd60, 8'd70, 32'hFFFFFFFF,
              mk(K_ON, 5'd0, 8'd60, 8'd70, 32'h3, 1'b0)};
    vt[4] = '{1'b1, 8'd60, 8'd50, 32'hFFFFFFFF,
              mk(K_ON, 5'd0, 8'd60, 8'd50, 32'h3, 1'b0)};
    vt[5] = '{1'b0, 8'd77, 8'd1, 32'hFFFFFFFF,
              mk(K_DROP, 5'd0, 8'd0, 8'd0, 32'h3, 1'b0)};
    vt[6] = '{1'b0, 8'd64, 8'd20, 32'hFFFFFFFF,
              mk(K_OFF, 5'd1, 8'd0, 8'd20, 32'h1, 1'b0)};
    vt[7] = '{1'b1, 8'd65, 8'd33, 32'hFFFFFFF0,
              mk(K_ON, 5'd4, 8'd65, 8'd33, 32'h11, 1'b0)};

    #3;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      voice_free = vt[i].free;
      send(vt[i].on, vt[i].key, vt[i].vel, vt[i].e);
    end

    // Fill all voices, then note-on with nothing free
    do_reset();
    voice_free = '1;
    for (int i = 0; i < VOICES; i++) begin
      mask = 32'((64'd1 << (i + 1)) - 64'd1);
      send(1'b1, 8'(i + 10), 8'(i + 1),
           mk(K_ON, 5'(i), 8'(i + 10), 8'(i + 1), mask, 1'b0));
    end
    voice_free = '0;
`ifdef VOICE_STEAL_EN
    send(1'b1, 8'd100, 8'd5, mk(K_ON, 5'd0, 8'd100, 8'd5, all_on, 1'b1));
`else
    send(1'b1, 8'd100, 8'd5, mk(K_DROP, 5'd0, 8'd0, 8'd0, all_on, 1'b0));
`endif

    // Reset in the middle of a scan aborts the event
    voice_free = '1;
    ev_note_on = 1'b1;
    ev_key     = 8'd50;
    ev_vel     = 8'd9;
    ev_valid   = 1'b1;
    @(posedge AUDIO_CLK); #1;
    ev_valid = 1'b0;
    repeat (10) @(posedge AUDIO_CLK);
    #1;
    check("scan_busy", {31'd0, ev_ready}, 32'd0);
    reset_reg_N = 1'b0;
    #2;
    check("abort_ready", {31'd0, ev_ready}, 32'd1);
    check("abort_keys", keys_on, 32'd0);
    @(posedge AUDIO_CLK); #1;
    reset_reg_N = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge AUDIO_CLK); #1;
      seen = seen | note_on | note_off | ev_dropped;
    end
    check("abort_pulse", {31'd0, seen}, 32'd0);
    check("abort_keys_after", keys_on, 32'd0);
    check("abort_ready_after", {31'd0, ev_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
